dds_phase_generator: RTL and testbench
======================================

# dds_phase_generator

Consumes the divided 1 MHz sample clock produced by the design's frequency divider and turns it into the DDS phase stream. It runs entirely in the 100 MHz domain and treats `clk_1MHz` as data. Each rising edge of `clk_1MHz` yields one sample tick; on that tick a 32-bit phase accumulator advances by the active frequency tuning word (FTW). Each tick produces a quarter-wave sine LUT address plus a sign flag for the downstream amplitude stage. New FTWs arrive via a valid/ready handshake and take effect only at a sample boundary.

## Interface
- `PHASE_W`, 32: accumulator / FTW width.
- `ADDR_W`, 10: quarter-wave LUT address width; requires `ADDR_W + 2 <= PHASE_W`.
- `FTW_RESET`, 32'h0041_8937: active FTW after reset (1 kHz at 1 MHz).
- Clocking: one clock; reset is synchronous and active-high.
- `clk_100MHz`  in  1  system clock, sole clock of the block.
- `rst`  in  1  synchronous, active-high reset.
- `clk_1MHz`  in  1  divided clock from the divider, sampled as a level.
- `en`  in  1  when low, ticks are ignored.
- `ftw_in`  in  PHASE_W  candidate tuning word.
- `ftw_valid`  in  1  `ftw_in` valid.
- `ftw_ready`  out  1  pending slot empty; a transfer occurs when `ftw_valid & ftw_ready` at a clock edge.
- `phase`  out  PHASE_W  accumulator value.
- `ftw_active`  out  PHASE_W  FTW currently used for increments.
- `lut_addr`  out  ADDR_W  quarter-wave address.
- `lut_negate`  out  1  the downstream stage negates the LUT value.
- `sample_stb`  out  1  one-cycle pulse when `phase`, `lut_addr` and `lut_negate` are new.

## Operation
- Edge detect:
  - Register `clk_d` samples `clk_1MHz`; it resets to 1.
  - `tick = clk_1MHz & ~clk_d & en`.
  - Because `clk_d` resets to 1, no spurious tick occurs if `clk_1MHz` is high at reset release.
- FTW buffering uses one pending slot (`pend_ftw`, `pend_full`).
  - `ftw_ready` is registered and equals `~pend_full`. It is 0 while `rst` is high.
  - On a transfer, `pend_ftw <= ftw_in` and `pend_full <= 1`.
- On `tick`:
  - `phase <= phase + ftw_active`, modulo 2^PHASE_W; the carry is discarded.
  - If `pend_full`: `ftw_active <= pend_ftw` and `pend_full <= 0`. The new word governs the following tick's increment.
- Same-cycle transfer and tick:
  - A transfer can only happen when the slot is empty, so the tick uses the old `ftw_active`.
  - The captured word waits for the next tick.
- Address mapping uses the updated phase `p`:
  - Quadrant `q = p[PHASE_W-1 -: 2]`.
  - Index `i = p[PHASE_W-3 -: ADDR_W]`.
  - `lut_addr = q[0] ? ~i : i`.
  - `lut_negate = q[1]`.
- `en` low:
  - `phase` holds and `ftw_active` holds.
  - The handshake still fills the slot.
  - Edges seen while `en` is low are lost, not deferred.
- Reset values:
  - `phase` = 0, `ftw_active` = FTW_RESET, slot empty.
  - `lut_addr` = 0, `lut_negate` = 0, `sample_stb` = 0, `ftw_ready` = 0.
- Reset mid-operation discards the pending word and restarts phase at 0.

## Timing
- Let cycle t be the cycle in which `tick` is high, i.e. the first cycle with `clk_1MHz` = 1.
- At the edge ending cycle t, `phase`, `ftw_active`, `lut_addr`, `lut_negate` and `sample_stb` update together.
- `sample_stb` is high for exactly cycle t+1.
- With a standard divider (50 high / 50 low), strobes are exactly 100 cycles apart.
- `ftw_ready` drops in the cycle after a transfer.
- `ftw_ready` rises in cycle t+1 if the slot was emptied by the tick in cycle t.
- First `ftw_ready` = 1 is in the cycle after `rst` deasserts.

## Structure
- Package `dds_pkg`:
  - `PHASE_W`, `ADDR_W`, `FTW_RESET`.
  - Function `ftw_for_hz(hz)` = hz·2^32/1e6.
- Sub-module `rising_edge_detect`:
  - Holds the `clk_d` register with reset value 1.
  - Outputs a one-cycle pulse.
  - Reused by later DDS control blocks.

## Test plan
- **Basic stepping:** FTW_RESET = 32'h4000_0000, divider-shaped `clk_1MHz`.
  - Phase sequence: 4000_0000, 8000_0000, C000_0000, 0000_0000.
  - `lut_addr`/`lut_negate` for those phases: 1023/0, 0/1, 1023/1, 0/0.
  - Strobe spacing is 100 cycles.
- **Mid-period load:** `ftw_in` = 32'h0100_0000, valid for one cycle, 30 cycles after a strobe.
  - `ftw_ready` is 0 in the next cycle.
  - `ftw_active` changes at the next strobe, while phase still advances by the old word.
  - The following strobe advances by 0100_0000.
- **Back-to-back words:** hold `ftw_valid` with word A, then word B.
  - A is accepted immediately.
  - B is accepted in cycle t+1 of the next tick.
  - Neither word is dropped.
- **Wrap-around:** `ftw_active` = FFFF_FFFF from phase 0.
  - Phase sequence: FFFF_FFFF, FFFF_FFFE.
  - `lut_negate` = 1 with `lut_addr` = 0.
- **Reset mid-operation:** reset with a word pending while `clk_1MHz` = 1.
  - After reset: phase 0, `ftw_active` = FTW_RESET.
  - No strobe until the next genuine rising edge.
- **Enable low:** `en` = 0 for 3 periods.
  - No strobes and `phase` frozen.
  - A word loaded meanwhile applies at the first tick after `en` = 1.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants and helpers for the DDS phase path.
// Holds default widths, reset tuning word and an FTW helper.
package dds_pkg;

    localparam int PHASE_W = 32;
    localparam int ADDR_W  = 10;
    localparam int QUAD_W  = 2;

    localparam logic [31:0] FTW_RESET = 32'h0041_8937;

    // Tuning word for a given output frequency at a 1 MHz sample rate.
    function automatic logic [31:0] ftw_for_hz(input logic [31:0] hz);
        logic [63:0] num;
        logic [63:0] quo;
        num = {hz, 32'h0};
        quo = num / 64'd1_000_000;
        return quo[31:0];
    endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// Level-to-pulse rising edge detector in the clk_100MHz domain.
// Ports: clk_100MHz, rst (sync, high), din (level), pulse (1-cycle).
module rising_edge_detect (
    input  logic clk_100MHz,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic din_d;

    // Resetting to 1 suppresses a false edge when din is already
    // high as reset releases.
    always_ff @(posedge clk_100MHz) begin
        if (rst) din_d <= 1'b1;
        else     din_d <= din;
    end

    assign pulse = din & ~din_d;

endmodule

// File: rtl/dds_phase_generator.sv
// DDS phase accumulator driven by 1 MHz sample ticks.
// Ports: clk_100MHz, rst, clk_1MHz, en, ftw_in/valid/ready,
//        phase, ftw_active, lut_addr, lut_negate, sample_stb.
module dds_phase_generator #(
    parameter int                  PHASE_W   = dds_pkg::PHASE_W,
    parameter int                  ADDR_W    = dds_pkg::ADDR_W,
    parameter logic [PHASE_W-1:0]  FTW_RESET = dds_pkg::FTW_RESET
) (
    input  logic               clk_100MHz,
    input  logic               rst,
    input  logic               clk_1MHz,
    input  logic               en,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic               ftw_valid,
    output logic               ftw_ready,
    output logic [PHASE_W-1:0] phase,
    output logic [PHASE_W-1:0] ftw_active,
    output logic [ADDR_W-1:0]  lut_addr,
    output logic               lut_negate,
    output logic               sample_stb
);

    import dds_pkg::*;

    logic               edge_pulse;
    logic               tick;
    logic               xfer;
    logic               pend_full;
    logic               pend_nxt;
    logic [PHASE_W-1:0] pend_ftw;
    logic [PHASE_W-1:0] phase_nxt;
    logic [QUAD_W-1:0]  quad;
    logic [ADDR_W-1:0]  idx;

    rising_edge_detect u_edge (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .din        (clk_1MHz),
        .pulse      (edge_pulse)
    );

    assign tick      = edge_pulse & en;
    assign xfer      = ftw_valid & ftw_ready;
    assign phase_nxt = phase + ftw_active;
    assign quad      = phase_nxt[PHASE_W-1 -: QUAD_W];
    assign idx       = phase_nxt[PHASE_W-QUAD_W-1 -: ADDR_W];

    // A transfer needs an empty slot, so it never collides with a
    // tick that drains a full one.
    always_comb begin
        pend_nxt = pend_full;
        if (tick) pend_nxt = 1'b0;
        if (xfer) pend_nxt = 1'b1;
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            phase      <= '0;
            ftw_active <= FTW_RESET;
            pend_ftw   <= '0;
            pend_full  <= 1'b0;
            ftw_ready  <= 1'b0;
            lut_addr   <= '0;
            lut_negate <= 1'b0;
            sample_stb <= 1'b0;
        end else begin
            sample_stb <= tick;
            pend_full  <= pend_nxt;
            ftw_ready  <= ~pend_nxt;
            if (xfer) pend_ftw <= ftw_in;
            if (tick) begin
                phase      <= phase_nxt;
                // Odd quadrants walk the quarter-wave table backwards.
                lut_addr   <= quad[0] ? ~idx : idx;
                lut_negate <= quad[1];
                if (pend_full) ftw_active <= pend_ftw;
            end
        end
    end

endmodule

// File: tb/tb_dds_phase_generator.sv
// Self-checking bench for dds_phase_generator.
// Reference model plus directed literal expectations.
module tb_dds_phase_generator;

    logic        clk_100MHz = 1'b0;
    logic        rst        = 1'b1;
    logic        clk_1MHz   = 1'b0;
    logic        en         = 1'b1;
    logic [31:0] ftw_in     = '0;
    logic        ftw_valid  = 1'b0;
    logic        ftw_ready;
    logic [31:0] phase;
    logic [31:0] ftw_active;
    logic [9:0]  lut_addr;
    logic        lut_negate;
    logic        sample_stb;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int div_cnt = 0;

    dds_phase_generator #(
        .PHASE_W   (32),
        .ADDR_W    (10),
        .FTW_RESET (32'h4000_0000)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .clk_1MHz   (clk_1MHz),
        .en         (en),
        .ftw_in     (ftw_in),
        .ftw_valid  (ftw_valid),
        .ftw_ready  (ftw_ready),
        .phase      (phase),
        .ftw_active (ftw_active),
        .lut_addr   (lut_addr),
        .lut_negate (lut_negate),
        .sample_stb (sample_stb)
    );

    initial forever #5 clk_100MHz = ~clk_100MHz;

    // Divider: 100-cycle period, 50 low then 50 high.
    initial forever begin
        @(posedge clk_100MHz);
        #2;
        cyc++;
        div_cnt  = (div_cnt == 99) ? 0 : div_cnt + 1;
        clk_1MHz = (div_cnt >= 50);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: sample-level behaviour in plain arithmetic.
    logic [31:0] m_phase, m_active;
    logic [31:0] m_q[$];
    logic [9:0]  m_addr;
    logic        m_neg, m_stb, m_ready, m_prev, m_tk, m_xf;
    bit          m_valid = 0;
    longint      quad, sub;

    initial forever begin
        @(posedge clk_100MHz);
        if (rst) begin
            m_phase  = 0;
            m_active = 32'h4000_0000;
            m_q.delete();
            m_ready  = 0;
            m_prev   = 1;
            m_stb    = 0;
            m_addr   = 0;
            m_neg    = 0;
        end else begin
            m_tk   = clk_1MHz && !m_prev && en;
            m_prev = clk_1MHz;
            m_xf   = ftw_valid && m_ready;
            m_stb  = m_tk;
            if (m_tk) begin
                m_phase = m_phase + m_active;
                quad    = longint'(m_phase) / 64'h4000_0000;
                sub     = (longint'(m_phase) % 64'h4000_0000) / 64'h10_0000;
                m_addr  = 10'((quad % 2 == 1) ? 1023 - sub : sub);
                m_neg   = (quad >= 2);
                if (m_q.size() > 0) m_active = m_q.pop_front();
            end
            if (m_xf) m_q.push_back(ftw_in);
            m_ready = (m_q.size() == 0);
        end
        m_valid = 1;
    end

    initial forever begin
        @(negedge clk_100MHz);
        if (m_valid) begin
            chk("model phase",      phase,      m_phase);
            chk("model ftw_active", ftw_active, m_active);
            chk("model lut_addr",   32'(lut_addr), 32'(m_addr));
            chk("model lut_negate", 32'(lut_negate), 32'(m_neg));
            chk("model sample_stb", 32'(sample_stb), 32'(m_stb));
            chk("model ftw_ready",  32'(ftw_ready),  32'(m_ready));
        end
    end

    task automatic wait_stb(output int at);
        int n;
        n = 0;
        do begin
            @(negedge clk_100MHz);
            n++;
        end while (!sample_stb && n < 250);
        at = cyc;
        if (!sample_stb) begin
            errors++;
            $display("FAIL wait_stb: no strobe within 250 cycles");
        end
    endtask

    task automatic send(input logic [31:0] w, output logic stb_acc);
        int n;
        n = 0;
        ftw_in    = w;
        ftw_valid = 1'b1;
        while (!ftw_ready && n < 300) begin
            @(negedge clk_100MHz);
            n++;
        end
        if (!ftw_ready) begin
            errors++;
            $display("FAIL send: word %h not accepted", w);
        end
        stb_acc = sample_stb;
        @(negedge clk_100MHz);
    endtask

    int          t_prev, t_now, nstb;
    logic        acc;
    logic [31:0] exp_ph[4];
    logic [9:0]  exp_ad[4];
    logic        exp_ng[4];

    initial begin
        exp_ph = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0};
        exp_ad = '{10'd1023, 10'd0, 10'd1023, 10'd0};
        exp_ng = '{1'b0, 1'b1, 1'b1, 1'b0};

        repeat (5) @(negedge clk_100MHz);
        chk("reset phase",  phase, 32'h0);
        chk("reset active", ftw_active, 32'h4000_0000);
        chk("reset ready",  32'(ftw_ready), 32'h0);
        chk("reset stb",    32'(sample_stb), 32'h0);
        chk("reset addr",   32'(lut_addr), 32'h0);
        rst = 1'b0;
        @(negedge clk_100MHz);
        chk("ready after reset", 32'(ftw_ready), 32'h1);

        // Basic stepping
        for (int k = 0; k < 4; k++) begin
            wait_stb(t_now);
            chk("step phase", phase, exp_ph[k]);
            chk("step addr",  32'(lut_addr), 32'(exp_ad[k]));
            chk("step neg",   32'(lut_negate), 32'(exp_ng[k]));
            if (k > 0) chk("stb spacing", 32'(t_now - t_prev), 32'd100);
            t_prev = t_now;
        end

        // Mid-period load
        repeat (30) @(negedge clk_100MHz);
        ftw_in    = 32'h0100_0000;
        ftw_valid = 1'b1;
        @(negedge clk_100MHz);
        ftw_valid = 1'b0;
        chk("ready after xfer", 32'(ftw_ready), 32'h0);
        wait_stb(t_now);
        chk("load phase old word", phase, 32'h4000_0000);
        chk("load active", ftw_active, 32'h0100_0000);
        wait_stb(t_now);
        chk("load phase new word", phase, 32'h4100_0000);

        // Back-to-back words
        send(32'h0200_0000, acc);
        send(32'h0300_0000, acc);
        ftw_valid = 1'b0;
        chk("B accepted at t+1", 32'(acc), 32'h1);
        chk("A active", ftw_active, 32'h0200_0000);
        chk("phase at A", phase, 32'h4200_0000);
        wait_stb(t_now);
        chk("B active", ftw_active, 32'h0300_0000);
        chk("phase after A", phase, 32'h4400_0000);

        // Reset mid-operation with a word pending, clk_1MHz high
        send(32'h1234_5678, acc);
        ftw_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        chk("mid reset ready", 32'(ftw_ready), 32'h0);
        rst = 1'b0;
        @(negedge clk_100MHz);
        chk("post reset phase",  phase, 32'h0);
        chk("post reset active", ftw_active, 32'h4000_0000);
        chk("post reset ready",  32'(ftw_ready), 32'h1);
        send(32'hC000_0000, acc);
        ftw_valid = 1'b0;
        wait_stb(t_now);
        chk("first stb at genuine edge", 32'(div_cnt), 32'd51);
        chk("post reset stb phase", phase, 32'h4000_0000);
        chk("pending discarded", ftw_active, 32'hC000_0000);

        // Wrap-around
        send(32'hFFFF_FFFF, acc);
        ftw_valid = 1'b0;
        wait_stb(t_now);
        chk("wrap to zero", phase, 32'h0);
        wait_stb(t_now);
        chk("wrap phase 1", phase, 32'hFFFF_FFFF);
        chk("wrap addr",    32'(lut_addr), 32'h0);
        chk("wrap neg",     32'(lut_negate), 32'h1);
        wait_stb(t_now);
        chk("wrap phase 2", phase, 32'hFFFF_FFFE);

        // Enable low for 3 periods
        en = 1'b0;
        send(32'h0010_0000, acc);
        ftw_valid = 1'b0;
        nstb = 0;
        repeat (300) begin
            @(negedge clk_100MHz);
            if (sample_stb) nstb++;
        end
        chk("no stb while en low", 32'(nstb), 32'h0);
        chk("phase frozen", phase, 32'hFFFF_FFFE);
        chk("active held", ftw_active, 32'hFFFF_FFFF);
        en = 1'b1;
        wait_stb(t_now);
        chk("en resume phase",  phase, 32'hFFFF_FFFD);
        chk("en resume active", ftw_active, 32'h0010_0000);
        wait_stb(t_now);
        chk("en new word phase", phase, 32'h000F_FFFD);

        repeat (3) @(negedge clk_100MHz);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
